keypoint_window_gen: RTL and testbench
======================================

KEYPOINT_WINDOW_GEN -- requirements
Module: keypoint_window_gen

Interface
REQ-001 Parameter: IMG_WIDTH, default 640, pixels per row; legal range 3..1024.
REQ-002 Parameter: IMG_HEIGHT, default 480, rows per frame; legal range 3..512.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  reset, asynchronous, active-high.
REQ-005 Port: pix_in  input  8  grayscale pixel, raster order.
REQ-006 Port: pix_valid  input  1  pix_in valid.
REQ-007 Port: pix_sof  input  1  qualifies pix_in as pixel (0,0) of a new frame.
REQ-008 Port: pix_ready  output  1  block accepts pix_in this cycle.
REQ-009 Port: win_top / win_mid / win_btm  output  24 each  3x3 window rows y-1 / y / y+1; byte [7:0] = column x-1, [15:8] = column x, [23:16] = column x+1.
REQ-010 Port: win_valid  output  1  window valid.
REQ-011 Port: win_ready  input  1  consumer accepts window.
REQ-012 Port: win_x  output  10  centre column x.
REQ-013 Port: win_y  output  9  centre row y.
REQ-014 Port: frame_done  output  1  one-cycle pulse, last pixel of frame accepted.

Function
REQ-015 Pixel accepted iff pix_valid && pix_ready; win accepted iff win_valid && win_ready.
REQ-016 pix_ready = !win_valid || win_ready, combinationally; at most one output stage.
REQ-017 Column counter col, row counter row advance per accepted pixel; col wraps IMG_WIDTH-1 -> 0 with row+1; row wraps IMG_HEIGHT-1 -> 0.
REQ-018 Accepted pixel with pix_sof=1 is treated as (0,0) regardless of counter values; counters continue from (0,0).
REQ-019 Two line buffers (IMG_WIDTH x 8 each) hold rows row-1 and row-2; read and write at index col, same cycle as acceptance.
REQ-020 Three 3-deep column shift registers (one per row) shift on each accepted pixel; they are not cleared at row start.
REQ-021 Phase state: FILL (row < 2), RUN (row >= 2); FILL -> RUN on the first accepted pixel of row 2; RUN -> FILL on frame wrap or sof.
REQ-022 In RUN, an accepted pixel at col >= 2 produces a window; no windows at image borders, no padding; (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows per frame.
REQ-023 Window is registered: win_valid rises the cycle after the completing pixel; win_x = col-1, win_y = row-1 of that pixel.
REQ-024 win_valid, win_* and win_x/win_y hold stable while win_valid && !win_ready.
REQ-025 win_valid clears after acceptance unless a new window loads in the same cycle (back-to-back throughput 1 window/cycle).
REQ-026 frame_done pulses one cycle after accepting pixel (IMG_WIDTH-1, IMG_HEIGHT-1); independent of win_ready.
REQ-027 Line buffer contents are not cleared at reset or sof; FILL gating guarantees stale data never appears in a valid window.

Reset
REQ-028 On reset assertion, asynchronously: win_valid=0, frame_done=0, win_top/mid/btm=0, win_x=0, win_y=0, col=0, row=0, phase=FILL.
REQ-029 pix_ready = 1 during and after reset (follows REQ-016).
REQ-030 Reset mid-frame discards partial frame; next accepted pixel is (0,0) with or without sof.

Verification (IMG_WIDTH=8, IMG_HEIGHT=6, pixel value = x + 8*y)
REQ-031 Reset asserted mid-stream -> all outputs zero same cycle, pix_ready=1.
REQ-032 Full frame, win_ready=1 -> first window: win_top=0x020100, win_mid=0x0A0908, win_btm=0x121110, win_x=1, win_y=1; total 24 windows, last at (6,4) with win_btm=0x2F2E2D.
REQ-033 win_ready held low 5 cycles with win_valid=1 -> outputs stable, pix_ready=0, no pixel dropped; window sequence identical to REQ-032.
REQ-034 pix_sof asserted at pixel 20 of a frame -> no window until 18 further accepted pixels; next window has win_x=1, win_y=1.
REQ-035 Last pixel (7,5) accepted -> frame_done=1 exactly one cycle; next frame pixels produce identical windows to the first frame.
REQ-036 pix_valid toggled randomly 50% -> window contents/coordinates match REQ-032 in order.

Source files
------------

// File: rtl/keypoint_window_gen_if.sv
// ---------------------------------------------------------------------------
// keypoint_window_gen_if
//   Bundles the pixel-stream input and the 3x3 window output of
//   keypoint_window_gen.
//   master : the environment side (drives pixels, accepts windows)
//   slave  : the window generator side
//   Signals:
//     pix_in[7:0], pix_valid, pix_sof -> pixel stream in, raster order
//     pix_ready                        <- generator can take a pixel
//     win_top/mid/btm[23:0]            <- window rows y-1 / y / y+1
//     win_x[9:0], win_y[8:0]           <- window centre coordinates
//     win_valid                        <- window present
//     win_ready                        -> consumer takes the window
//     frame_done                       <- pulse after last pixel of a frame
// ---------------------------------------------------------------------------
interface keypoint_window_gen_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic        pix_sof;
  logic        pix_ready;
  logic [23:0] win_top;
  logic [23:0] win_mid;
  logic [23:0] win_btm;
  logic        win_valid;
  logic        win_ready;
  logic [9:0]  win_x;
  logic [8:0]  win_y;
  logic        frame_done;

  modport master (
    output pix_in, pix_valid, pix_sof, win_ready,
    input  pix_ready, win_top, win_mid, win_btm, win_valid, win_x, win_y,
           frame_done
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof, win_ready,
    output pix_ready, win_top, win_mid, win_btm, win_valid, win_x, win_y,
           frame_done
  );
endinterface

// File: rtl/keypoint_window_gen.sv
// ---------------------------------------------------------------------------
// keypoint_window_gen
//   Turns a raster-order 8-bit grayscale pixel stream into 3x3 neighbourhood
//   windows, one per interior pixel of the image, for keypoint detectors.
//   Two line buffers hold the previous two rows; small column shift registers
//   hold the previous two columns of each of the three rows.
//   Ports:
//     clk   : single clock, rising edge
//     reset : asynchronous, active-high
//     bus   : keypoint_window_gen_if.slave (pixel stream in, window out)
//   Parameters:
//     IMG_WIDTH  : pixels per row (3..1024)
//     IMG_HEIGHT : rows per frame (3..512)
// ---------------------------------------------------------------------------
module keypoint_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input logic                 clk,
  input logic                 reset,
  keypoint_window_gen_if.slave bus
);

  localparam int          AW       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [9:0]  COL_LAST = 10'(IMG_WIDTH - 1);
  localparam logic [8:0]  ROW_LAST = 9'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, RUN} phase_t;

  phase_t      phase;
  logic [9:0]  col;
  logic [8:0]  row;

  logic [7:0]  line_a [IMG_WIDTH];
  logic [7:0]  line_b [IMG_WIDTH];

  logic [15:0] sr_top;
  logic [15:0] sr_mid;
  logic [15:0] sr_btm;

  logic [23:0] win_top_q;
  logic [23:0] win_mid_q;
  logic [23:0] win_btm_q;
  logic [9:0]  win_x_q;
  logic [8:0]  win_y_q;
  logic        win_valid_q;
  logic        frame_done_q;

  logic        pix_ready_c;
  logic        accept;
  logic        load_win;
  logic        last_col;
  logic        last_row;
  logic        in_run;
  logic [9:0]  cur_col;
  logic [8:0]  cur_row;
  logic [9:0]  nxt_col;
  logic [8:0]  nxt_row;
  logic [AW-1:0] idx;
  logic [7:0]  rd_a;
  logic [7:0]  rd_b;
  logic [23:0] nxt_top;
  logic [23:0] nxt_mid;
  logic [23:0] nxt_btm;

  // Handshake, effective pixel position and the next window contents.
  // A start-of-frame pixel overrides the counters so it is always (0,0).
  // Each shift register keeps the two previous columns; the incoming column
  // completes the 3-wide row, newest column in the top byte.
  always_comb begin
    pix_ready_c = !win_valid_q || bus.win_ready;
    accept      = bus.pix_valid && pix_ready_c;
    cur_col     = bus.pix_sof ? 10'd0 : col;
    cur_row     = bus.pix_sof ? 9'd0  : row;
    last_col    = (cur_col == COL_LAST);
    last_row    = (cur_row == ROW_LAST);
    nxt_col     = last_col ? 10'd0 : cur_col + 10'd1;
    nxt_row     = cur_row;
    if (last_col) begin
      nxt_row = last_row ? 9'd0 : cur_row + 9'd1;
    end
    idx      = cur_col[AW-1:0];
    rd_a     = line_a[idx];
    rd_b     = line_b[idx];
    nxt_top  = {rd_b, sr_top};
    nxt_mid  = {rd_a, sr_mid};
    nxt_btm  = {bus.pix_in, sr_btm};
    // Row 2 is the first row with two valid rows above it; the pixel that
    // moves the phase to RUN must already count as running.
    in_run   = ((phase == RUN) && !bus.pix_sof) || (cur_row == 9'd2);
    load_win = accept && in_run && (cur_col >= 10'd2);
  end

  // Position counters, phase, column shift registers and the single
  // registered output stage. A held window stays put until the consumer
  // takes it; a new window can replace it in the very cycle it is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      phase        <= FILL;
      sr_top       <= '0;
      sr_mid       <= '0;
      sr_btm       <= '0;
      win_top_q    <= '0;
      win_mid_q    <= '0;
      win_btm_q    <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= accept && last_col && last_row;
      if (accept) begin
        col    <= nxt_col;
        row    <= nxt_row;
        sr_top <= nxt_top[23:8];
        sr_mid <= nxt_mid[23:8];
        sr_btm <= nxt_btm[23:8];
        if (bus.pix_sof || (last_col && last_row)) begin
          phase <= FILL;
        end else if (cur_row == 9'd2) begin
          phase <= RUN;
        end
      end
      if (load_win) begin
        win_top_q   <= nxt_top;
        win_mid_q   <= nxt_mid;
        win_btm_q   <= nxt_btm;
        win_x_q     <= cur_col - 10'd1;
        win_y_q     <= cur_row - 9'd1;
        win_valid_q <= 1'b1;
      end else if (bus.win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  // Line buffers: each accepted pixel pushes the column one row further up.
  // They are never cleared; the FILL phase keeps stale rows out of windows.
  always_ff @(posedge clk) begin
    if (accept) begin
      line_b[idx] <= rd_a;
      line_a[idx] <= bus.pix_in;
    end
  end

  assign bus.pix_ready  = pix_ready_c;
  assign bus.win_top    = win_top_q;
  assign bus.win_mid    = win_mid_q;
  assign bus.win_btm    = win_btm_q;
  assign bus.win_x      = win_x_q;
  assign bus.win_y      = win_y_q;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_keypoint_window_gen.sv
// ---------------------------------------------------------------------------
// tb_keypoint_window_gen
//   Testbench for keypoint_window_gen on an 8x6 image whose pixel value is
//   x + 8*y. Expected windows are built from that formula and queued when a
//   completing pixel is accepted; they are popped when the window is taken.
// ---------------------------------------------------------------------------
module tb_keypoint_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    logic [23:0] top;
    logic [23:0] mid;
    logic [23:0] btm;
    logic [9:0]  x;
    logic [8:0]  y;
  } win_t;

  typedef struct {
    string name;
    int    n_pix;
    int    valid_pct;
    int    ready_pct;
    int    sof_idx;
    int    stall_at;
    int    exp_win;
  } scen_t;

  logic clk = 1'b0;
  logic reset;

  keypoint_window_gen_if bus_if();

  keypoint_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  win_t  exp_q[$];
  win_t  first_win;
  win_t  last_win;
  bit    have_first = 1'b0;
  bit    exp_fd     = 1'b0;
  int    checks     = 0;
  int    passes     = 0;
  int    bx         = 0;
  int    by         = 0;
  int    acc_pix    = 0;
  int    win_cnt    = 0;
  int    fd_cnt     = 0;
  scen_t scen[5];

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'(x + 8 * y);
  endfunction

  function automatic win_t exp_window(input int x, input int y);
    win_t w;
    w.top = {pix(x + 1, y - 1), pix(x, y - 1), pix(x - 1, y - 1)};
    w.mid = {pix(x + 1, y),     pix(x, y),     pix(x - 1, y)};
    w.btm = {pix(x + 1, y + 1), pix(x, y + 1), pix(x - 1, y + 1)};
    w.x   = 10'(x);
    w.y   = 9'(y);
    return w;
  endfunction

  // One comparison: counts it, reports it on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // All outputs must be at their reset values while reset is held.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_win_valid"},  bus_if.win_valid,  0);
    checkOutput({tag, "_frame_done"}, bus_if.frame_done, 0);
    checkOutput({tag, "_win_top"},    bus_if.win_top,    0);
    checkOutput({tag, "_win_mid"},    bus_if.win_mid,    0);
    checkOutput({tag, "_win_btm"},    bus_if.win_btm,    0);
    checkOutput({tag, "_win_x"},      bus_if.win_x,      0);
    checkOutput({tag, "_win_y"},      bus_if.win_y,      0);
    checkOutput({tag, "_pix_ready"},  bus_if.pix_ready,  1);
  endtask

  // Mid-cycle observation: compare against the model, then advance the
  // model for the handshakes that the coming rising edge will perform.
  task automatic observe();
    checkOutput("win_valid", bus_if.win_valid, (exp_q.size() != 0));
    checkOutput("pix_ready", bus_if.pix_ready, (exp_q.size() == 0) || bus_if.win_ready);
    checkOutput("frame_done", bus_if.frame_done, exp_fd);
    if (bus_if.frame_done) fd_cnt++;
    if (bus_if.win_valid && exp_q.size() != 0) begin
      checkOutput("win_top", bus_if.win_top, exp_q[0].top);
      checkOutput("win_mid", bus_if.win_mid, exp_q[0].mid);
      checkOutput("win_btm", bus_if.win_btm, exp_q[0].btm);
      checkOutput("win_x",   bus_if.win_x,   exp_q[0].x);
      checkOutput("win_y",   bus_if.win_y,   exp_q[0].y);
    end
    exp_fd = 1'b0;
    if (bus_if.win_valid && bus_if.win_ready) begin
      last_win.top = bus_if.win_top;
      last_win.mid = bus_if.win_mid;
      last_win.btm = bus_if.win_btm;
      last_win.x   = bus_if.win_x;
      last_win.y   = bus_if.win_y;
      if (!have_first) begin
        first_win  = last_win;
        have_first = 1'b1;
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      win_cnt++;
    end
    if (bus_if.pix_valid && bus_if.pix_ready) begin
      if (bus_if.pix_sof) begin
        bx = 0;
        by = 0;
      end
      if (bx >= 2 && by >= 2) exp_q.push_back(exp_window(bx - 1, by - 1));
      exp_fd = (bx == W - 1) && (by == H - 1);
      bx++;
      if (bx == W) begin
        bx = 0;
        by++;
        if (by == H) by = 0;
      end
      acc_pix++;
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and observe at
  // the falling edge.
  task automatic applyStimulus(input bit v, input bit sof, input bit rdy);
    bus_if.pix_valid = v;
    bus_if.pix_sof   = v && sof;
    bus_if.pix_in    = sof ? 8'h00 : pix(bx, by);
    bus_if.win_ready = rdy;
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  // Stream n accepted pixels; optional sof at a given pixel index and an
  // optional 5-cycle consumer stall once a given window is pending.
  task automatic send(input int n, input int vpct, input int rpct,
                      input int sof_idx, input int stall_at);
    int start;
    int cycles;
    int stall_left;
    int base_win;
    bit v;
    bit r;
    bit s;
    start      = acc_pix;
    base_win   = win_cnt;
    cycles     = 0;
    stall_left = 5;
    while ((acc_pix - start) < n && cycles < 4000) begin
      v = ($urandom_range(99) < vpct);
      r = ($urandom_range(99) < rpct);
      s = ((acc_pix - start) == sof_idx);
      if (stall_at >= 0 && (win_cnt - base_win) == stall_at &&
          exp_q.size() != 0 && stall_left > 0) begin
        v = 1'b1;
        r = 1'b0;
        stall_left--;
      end
      applyStimulus(v, s, r);
      cycles++;
    end
    checkOutput("pixels_accepted", acc_pix - start, n);
    if (stall_at >= 0) checkOutput("stall_cycles", 5 - stall_left, 5);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w0;
    int f0;

    scen[0] = '{"full",   48, 100, 100,  0, -1, 24};
    scen[1] = '{"second", 48, 100, 100, -1, -1, 24};
    scen[2] = '{"stall",  48, 100, 100, -1,  3, 24};
    scen[3] = '{"rvalid", 48,  50, 100, -1, -1, 24};
    scen[4] = '{"rboth",  48,  60,  70,  0, -1, 24};

    reset            = 1'b1;
    bus_if.pix_in    = 8'h00;
    bus_if.pix_valid = 1'b0;
    bus_if.pix_sof   = 1'b0;
    bus_if.win_ready = 1'b0;
    #12;
    checkResetState("por");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      w0 = win_cnt;
      f0 = fd_cnt;
      send(scen[i].n_pix, scen[i].valid_pct, scen[i].ready_pct,
           scen[i].sof_idx, scen[i].stall_at);
      drain(4);
      checkOutput({scen[i].name, "_windows"},     win_cnt - w0, scen[i].exp_win);
      checkOutput({scen[i].name, "_queue_empty"}, exp_q.size(), 0);
      checkOutput({scen[i].name, "_frame_done"},  fd_cnt - f0,  1);
      if (i == 0) begin
        checkOutput("first_top", first_win.top, 24'h020100);
        checkOutput("first_mid", first_win.mid, 24'h0A0908);
        checkOutput("first_btm", first_win.btm, 24'h121110);
        checkOutput("first_x",   first_win.x,   1);
        checkOutput("first_y",   first_win.y,   1);
        checkOutput("last_btm",  last_win.btm,  24'h2F2E2D);
        checkOutput("last_x",    last_win.x,    6);
        checkOutput("last_y",    last_win.y,    4);
      end
    end

    // Restart with sof after 20 pixels of a frame.
    w0 = win_cnt;
    send(20, 100, 100, -1, -1);
    drain(3);
    checkOutput("sof_pre_windows", win_cnt - w0, 2);
    w0 = win_cnt;
    f0 = fd_cnt;
    send(18, 100, 100, 0, -1);
    drain(3);
    checkOutput("sof_gap_no_window", win_cnt - w0, 0);
    send(1, 100, 100, -1, -1);
    drain(3);
    checkOutput("sof_first_count", win_cnt - w0, 1);
    checkOutput("sof_first_x",     last_win.x,   1);
    checkOutput("sof_first_y",     last_win.y,   1);
    checkOutput("sof_first_top",   last_win.top, 24'h020100);
    send(29, 100, 100, -1, -1);
    drain(3);
    checkOutput("sof_frame_windows",    win_cnt - w0, 24);
    checkOutput("sof_frame_done_count", fd_cnt - f0,  1);

    // Reset while a window is being held.
    send(30, 100, 100, -1, -1);
    bus_if.pix_valid = 1'b0;
    bus_if.win_ready = 1'b0;
    #1;
    checkOutput("pre_reset_win_valid", bus_if.win_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    checkResetState("mid");
    exp_q.delete();
    bx     = 0;
    by     = 0;
    exp_fd = 1'b0;
    @(negedge clk);
    checkResetState("held");
    reset = 1'b0;
    @(posedge clk);
    #1;

    // After reset the next pixel is (0,0) even without sof.
    w0 = win_cnt;
    f0 = fd_cnt;
    send(48, 100, 100, -1, -1);
    drain(4);
    checkOutput("post_reset_windows",    win_cnt - w0, 24);
    checkOutput("post_reset_frame_done", fd_cnt - f0,  1);
    checkOutput("post_reset_last_btm",   last_win.btm, 24'h2F2E2D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
